// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART phi2 bus initiator: register map,
// status bit positions and the bus-cycle FSM state encoding.
package uart_bus_pkg;

    localparam logic [1:0] UART_ADDR_STATUS = 2'd0;
    localparam logic [1:0] UART_ADDR_RXDATA = 2'd1;
    localparam logic [1:0] UART_ADDR_TXDATA = 2'd2;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_EMPTY = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_LOW,
        ST_HIGH
    } bus_state_t;

endpackage

// File: rtl/uart_bus_initiator_phi2_gen.sv
// Free-running phi2 generator: phi2 toggles every PHI2_HALF clks.
// Ports: i_clk, i_nrst (async low) -> o_phi2, o_rise_tick, o_fall_tick.
module phi2_gen #(
    parameter int PHI2_HALF = 8
) (
    input  logic i_clk,
    input  logic i_nrst,
    output logic o_phi2,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int CW = (PHI2_HALF > 1) ? $clog2(PHI2_HALF) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phi2;
    logic          w_tick;

    assign w_tick = (r_cnt == CW'(PHI2_HALF - 1));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cnt  <= '0;
            r_phi2 <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_phi2 <= ~r_phi2;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Ticks mark the clk edge on which phi2 changes level.
    assign o_phi2      = r_phi2;
    assign o_rise_tick = w_tick & ~r_phi2;
    assign o_fall_tick = w_tick &  r_phi2;

endmodule

// File: rtl/uart_bus_initiator.sv
// Bus master turning valid/ready commands into single 6502-style phi2
// read/write cycles on addr/ncs/nwe/data; one-clk rsp_valid on completion.
module uart_bus_initiator
    import uart_bus_pkg::*;
#(
    parameter int PHI2_HALF = 8,
    parameter int ADDR_W    = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              phi2,
    output logic [ADDR_W-1:0] addr,
    output logic              ncs,
    output logic              nwe,
    output logic [7:0]        data_out,
    output logic              data_oe,
    input  logic [7:0]        data_in
);

    bus_state_t        r_state;
    bus_state_t        w_state_nx;

    logic              w_rise;
    logic              w_fall;

    logic              r_hold_we;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [7:0]        r_hold_wdata;
    logic              r_ncs;
    logic              r_nwe;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data_out;
    logic              r_data_oe;
    logic              r_rsp_valid;
    logic [7:0]        r_rsp_rdata;

    logic              w_hold_we_nx;
    logic [ADDR_W-1:0] w_hold_addr_nx;
    logic [7:0]        w_hold_wdata_nx;
    logic              w_ncs_nx;
    logic              w_nwe_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [7:0]        w_data_out_nx;
    logic              w_data_oe_nx;
    logic              w_rsp_valid_nx;
    logic [7:0]        w_rsp_rdata_nx;

    phi2_gen #(
        .PHI2_HALF (PHI2_HALF)
    ) u_phi2 (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .o_phi2      (phi2),
        .o_rise_tick (w_rise),
        .o_fall_tick (w_fall)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: if (cmd_valid) w_state_nx = ST_PEND;
            ST_PEND: if (w_fall)    w_state_nx = ST_LOW;
            ST_LOW:  if (w_rise)    w_state_nx = ST_HIGH;
            ST_HIGH: if (w_fall)    w_state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered bus/response outputs.
    always_comb begin
        w_hold_we_nx    = r_hold_we;
        w_hold_addr_nx  = r_hold_addr;
        w_hold_wdata_nx = r_hold_wdata;
        w_ncs_nx        = r_ncs;
        w_nwe_nx        = r_nwe;
        w_addr_nx       = r_addr;
        w_data_out_nx   = r_data_out;
        w_data_oe_nx    = r_data_oe;
        w_rsp_valid_nx  = 1'b0;
        w_rsp_rdata_nx  = r_rsp_rdata;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_hold_we_nx    = cmd_we;
                    w_hold_addr_nx  = cmd_addr;
                    w_hold_wdata_nx = cmd_wdata;
                end
            end
            ST_PEND: begin
                // Cycle opens on a phi2 fall: address phase is phi2 low.
                if (w_fall) begin
                    w_ncs_nx  = 1'b0;
                    w_addr_nx = r_hold_addr;
                    w_nwe_nx  = ~r_hold_we;
                end
            end
            ST_LOW: begin
                if (w_rise && r_hold_we) begin
                    w_data_out_nx = r_hold_wdata;
                    w_data_oe_nx  = 1'b1;
                end
            end
            ST_HIGH: begin
                // data_in is sampled on the last clk of phi2 high.
                if (w_fall) begin
                    if (!r_hold_we) begin
                        w_rsp_rdata_nx = data_in;
                    end
                    w_ncs_nx       = 1'b1;
                    w_nwe_nx       = 1'b1;
                    w_data_oe_nx   = 1'b0;
                    w_data_out_nx  = 8'h00;
                    w_rsp_valid_nx = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_hold_we    <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_wdata <= 8'h00;
            r_ncs        <= 1'b1;
            r_nwe        <= 1'b1;
            r_addr       <= '0;
            r_data_out   <= 8'h00;
            r_data_oe    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 8'h00;
        end else begin
            r_hold_we    <= w_hold_we_nx;
            r_hold_addr  <= w_hold_addr_nx;
            r_hold_wdata <= w_hold_wdata_nx;
            r_ncs        <= w_ncs_nx;
            r_nwe        <= w_nwe_nx;
            r_addr       <= w_addr_nx;
            r_data_out   <= w_data_out_nx;
            r_data_oe    <= w_data_oe_nx;
            r_rsp_valid  <= w_rsp_valid_nx;
            r_rsp_rdata  <= w_rsp_rdata_nx;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign addr      = r_addr;
    assign ncs       = r_ncs;
    assign nwe       = r_nwe;
    assign data_out  = r_data_out;
    assign data_oe   = r_data_oe;

endmodule

// File: doc/uart_bus_initiator.md
Name: uart_bus_initiator

Overview:
Bus master that generates 6502-style phi2 bus cycles toward the UART register interface: status at addr 0, rx data at addr 1, tx data at addr 2. It converts single-beat commands (valid/ready) into one complete phi2 read or write cycle and returns a one-cycle response. It serves as the on-FPGA host or test driver for the UART peripheral and sits on the same data, address, ncs, nwe and phi2 lines the CPU would drive. The tristate is kept outside this block as separate data_out/data_oe/data_in signals.

Parameters:
PHI2_HALF, 8, clk cycles per phi2 half-period (8 gives 1 MHz phi2 from 16 MHz clk); minimum 4
ADDR_W, 2, register address width

Ports:
clk  in  1  system clock, 16 MHz
nrst  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge clk
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  register address
cmd_wdata  in  8  write data
rsp_valid  out  1  one-cycle pulse: bus cycle complete
rsp_rdata  out  8  read data; valid with rsp_valid, held until the next read completes
phi2  out  1  free-running bus clock
addr  out  ADDR_W  bus address
ncs  out  1  chip select, active-low
nwe  out  1  1 = read, 0 = write
data_out  out  8  bus write data
data_oe  out  1  data bus output enable
data_in  in  8  bus read data

Behaviour:
- Reset (async, nrst=0), all registered:
  - phi2=0, cnt=0, state=IDLE
  - ncs=1, nwe=1, addr=0
  - data_out=0, data_oe=0
  - rsp_valid=0, rsp_rdata=0
  - cmd_ready=1 (combinational: state==IDLE)
- phi2 generator:
  - cnt counts 0..PHI2_HALF-1.
  - At cnt==PHI2_HALF-1: cnt<=0 and phi2<=~phi2.
  - fall_tick = that edge with phi2==1; rise_tick = that edge with phi2==0.
  - phi2 runs continuously, including while idle.
- FSM states: IDLE, PEND, LOW, HIGH.
  - IDLE: on cmd_valid, latch we/addr/wdata into holding regs; go to PEND.
  - PEND: on fall_tick, drive ncs<=0, addr<=hold_addr, nwe<=~hold_we; go to LOW.
  - LOW (phi2 low, address phase): on rise_tick, if write then data_out<=hold_wdata and data_oe<=1; go to HIGH.
  - HIGH (phi2 high, data phase): on fall_tick:
    - if read, rsp_rdata<=data_in (sampled at the last high cycle);
    - ncs<=1, nwe<=1, data_oe<=0, data_out<=0; addr holds its value;
    - rsp_valid<=1 for exactly one clk; go to IDLE.
- Timing:
  - ncs is low for exactly 2*PHI2_HALF clks: one full phi2 period, low phase then high phase.
  - Write data is driven for exactly PHI2_HALF clks, aligned to phi2 high.
  - Latency from acceptance to rsp_valid: 2*PHI2_HALF+1 to 4*PHI2_HALF clks, depending on phi2 phase at acceptance.
- Back-to-back commands: a new command may be accepted the cycle after rsp_valid. Its bus cycle starts at the next fall_tick, so ncs is high for at least one full phi2 period between transactions.
- Busy:
  - cmd_ready=0 outside IDLE.
  - cmd_valid while busy is ignored; the source holds it.
  - Command inputs are not sampled again until IDLE.
- Writes leave rsp_rdata unchanged.
- Reset mid-transaction: bus returns to idle immediately (ncs=1, data_oe=0); no rsp_valid is issued; phi2 restarts low.
- Width rules: addr is zero-extended from cmd_addr; no other arithmetic.

Decomposition:
- Shared package uart_bus_pkg:
  - UART_ADDR_STATUS=2'd0, UART_ADDR_RXDATA=2'd1, UART_ADDR_TXDATA=2'd2
  - status bit indices: STAT_TX_FULL=0, STAT_RX_EMPTY=1
  - FSM state enum (IDLE, PEND, LOW, HIGH)
- Sub-module phi2_gen (PHI2_HALF): outputs phi2, rise_tick, fall_tick.

Test Plan:
- Reset values: nrst low for 3 clks -> all outputs at reset values, cmd_ready=1, phi2 period 2*PHI2_HALF after release (16 clks at default).
- Write: cmd_we=1, addr=2, wdata=8'h41 -> at next fall_tick ncs=0, nwe=0, addr=2; data_oe=1 and data_out=8'h41 for exactly 8 clks of phi2 high; ncs=1 after fall; single rsp_valid pulse.
- Read: cmd_we=0, addr=0, bus model drives 8'h02 from 2 clks after phi2 rise -> rsp_valid with rsp_rdata=8'h02; data_oe stays 0 throughout.
- Busy/back-to-back: cmd_valid held continuously with two commands -> second accepted only the cycle after the first rsp_valid; ncs high for at least 16 clks between the two cycles.
- Reset mid-transaction: nrst low during HIGH of a write -> ncs=1 and data_oe=0 immediately; no rsp_valid; next command completes normally.
- PHI2_HALF=4: read of addr 1 returning 8'hA5 -> phi2 period 8 clks, rsp_rdata=8'hA5.
